receiver_fsm: RTL and testbench

//  UART serial receiver; the line-side peer of the transmitter FSM. Same frame options (7/8 data, none/odd/even

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/receiver_fsm.sv | 249 ++++++++++++++++++++++++
 tb/tb_receiver_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity codes and tick counter width.
// Used by both the receiver and the transmitter FSMs.
package uart_pkg;

  // Default oversampling ratio of the shared baud generator.
  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned TICK_W          = $clog2(UART_OVERSAMPLE);

  // Parity configuration codes; 2'b11 also means no parity.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } uart_state_e;

  // True when the code selects odd or even parity.
  function automatic logic parity_enabled(input logic [1:0] par);
    return (par == PAR_ODD) || (par == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the line through the flop chain; reset to 1 so idle is not seen as a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/receiver_fsm.sv
// UART receiver: oversamples rx, deframes LSB-first, checks parity and stop bits and
// pulses rx_done_o with the received word and error flags.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module receiver_fsm
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sam_tick_i,
  input  logic       rx_i,
  input  logic [1:0] parity_i,
  input  logic       stop_bit_i,
  input  logic       bits_num_i,
  output logic [7:0] data_out_o,
  output logic       rx_done_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       break_det_o
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] MidTick = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] EndTick = TickW'(OVERSAMPLE - 1);

  uart_state_e      state_q, state_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       par_cfg_q, par_cfg_d;
  logic             stop2_q, stop2_d;
  logic             bits8_q, bits8_d;
  logic             par_bit_q, par_bit_d;
  logic             par_err_q, par_err_d;

  logic [7:0] data_out_q, data_out_d;
  logic       rx_done_q, rx_done_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;
  logic       break_det_q, break_det_d;

  logic       rx_s;
  logic [7:0] rx_word;
  logic [2:0] last_bit;
  logic       par_en;
  logic       par_exp;
  logic       frame_end;
  logic       end_ferr;
  logic       brk_cand;
  logic       end_brk;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  // Bits enter at the MSB, so a 7-bit frame ends up one position high and is realigned here.
  assign rx_word  = bits8_q ? shift_q : {1'b0, shift_q[7:1]};
  assign last_bit = bits8_q ? 3'd7 : 3'd6;
  assign par_en   = parity_enabled(par_cfg_q);
  assign par_exp  = (par_cfg_q == PAR_EVEN) ? ^rx_word : ~(^rx_word);

`ifdef UART_RX_BREAK_DETECT_EN
  assign end_brk = brk_cand;
`else
  logic unused_brk;
  assign unused_brk = brk_cand;
  assign end_brk    = 1'b0;
`endif

  // State and frame datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_cfg_q  <= PAR_NONE;
      stop2_q    <= 1'b0;
      bits8_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_cfg_q  <= par_cfg_d;
      stop2_q    <= stop2_d;
      bits8_q    <= bits8_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
    end
  end

  // Next-state logic: tick counting, mid-bit sampling and frame-end detection.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_cfg_d  = par_cfg_q;
    stop2_d    = stop2_q;
    bits8_d    = bits8_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frame_end  = 1'b0;
    end_ferr   = 1'b0;
    brk_cand   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d    = StStart;
          tick_cnt_d = '0;
        end
      end

      StStart: begin
        if (sam_tick_i) begin
          if (tick_cnt_q == MidTick) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              // Start bit confirmed: freeze the frame format for this frame.
              par_cfg_d = parity_i;
              stop2_d   = stop_bit_i;
              bits8_d   = bits_num_i;
              bit_cnt_d = '0;
              par_bit_d = 1'b0;
              par_err_d = 1'b0;
              state_d   = StData;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end

      StData: begin
        if (sam_tick_i) begin
          if (tick_cnt_q == EndTick) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[7:1]};
            if (bit_cnt_q == last_bit) begin
              bit_cnt_d = '0;
              state_d   = par_en ? StParity : StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end

      StParity: begin
        if (sam_tick_i) begin
          if (tick_cnt_q == EndTick) begin
            tick_cnt_d = '0;
            par_bit_d  = rx_s;
            par_err_d  = rx_s ^ par_exp;
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end

      StStop: begin
        if (sam_tick_i) begin
          if (tick_cnt_q == EndTick) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              frame_end = 1'b1;
              end_ferr  = 1'b1;
              // Break: all-zero data, zero parity bit and a low first stop bit.
              brk_cand  = (bit_cnt_q == 3'd0) && (rx_word == 8'h00) && (!par_en || !par_bit_q);
              state_d   = StWaitHigh;
            end else if (stop2_q && (bit_cnt_q == 3'd0)) begin
              bit_cnt_d = 3'd1;
            end else begin
              frame_end = 1'b1;
              state_d   = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
          end
        end
      end

      StWaitHigh: begin
        // A line held low must go idle before another start bit is accepted.
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output next-state: results update only on the clock that ends a frame.
  always_comb begin
    rx_done_d    = frame_end;
    break_det_d  = frame_end & end_brk;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    if (frame_end) begin
      data_out_d   = end_brk ? 8'h00 : rx_word;
      parity_err_d = par_err_q;
      frame_err_d  = end_ferr;
    end
  end

  // Output registers; rx_done and break_det are single-cycle pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_out_q   <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
    end
  end

  assign data_out_o   = data_out_q;
  assign rx_done_o    = rx_done_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign break_det_o  = break_det_q;

endmodule

// File: tb/tb_receiver_fsm.sv
// Scoreboard bench for receiver_fsm: a serial driver pushes the expected result of each
// frame; a monitor pops and compares whenever rx_done is seen.
module tb_receiver_fsm;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

`ifdef UART_RX_BREAK_DETECT_EN
  localparam logic BrkExp = 1'b1;
`else
  localparam logic BrkExp = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sam_tick = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] parity = PAR_NONE;
  logic       stop_bit = 1'b0;
  logic       bits_num = 1'b1;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   rst_req = 0;
  int   rst_seen = 0;
  bit   end_req = 1'b0;

  receiver_fsm dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sam_tick_i  (sam_tick),
    .rx_i        (rx),
    .parity_i    (parity),
    .stop_bit_i  (stop_bit),
    .bits_num_i  (bits_num),
    .data_out_o  (data_out),
    .rx_done_o   (rx_done),
    .parity_err_o(parity_err),
    .frame_err_o (frame_err),
    .break_det_o (break_det)
  );

  always #5 clk = ~clk;

  // sam_tick: one clock in every four
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      sam_tick = 1'b1;
      @(negedge clk);
      sam_tick = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: scoreboard checks, reset-value checks and the final summary.
  always @(negedge clk) begin
    exp_t e;
    if (rst_req != rst_seen) begin
      rst_seen = rst_req;
      cmp("reset_data_out", data_out, 8'h00);
      cmp("reset_rx_done", {7'd0, rx_done}, 8'h00);
      cmp("reset_parity_err", {7'd0, parity_err}, 8'h00);
      cmp("reset_frame_err", {7'd0, frame_err}, 8'h00);
      cmp("reset_break_det", {7'd0, break_det}, 8'h00);
    end
    if (rx_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rx_done: got rx_done=1 data_out=%h, required no frame (t=%0t)",
                 data_out, $time);
      end else begin
        e = exp_q.pop_front();
        cmp("data_out", data_out, e.data);
        cmp("parity_err", {7'd0, parity_err}, {7'd0, e.perr});
        cmp("frame_err", {7'd0, frame_err}, {7'd0, e.ferr});
        cmp("break_det", {7'd0, break_det}, {7'd0, e.brk});
      end
    end else if (break_det !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL lone_break_det: got break_det=%b without rx_done, required 0", break_det);
    end
    if (end_req) begin
      cmp("frames_outstanding", 8'(exp_q.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (sam_tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  // Drive one frame LSB-first; the parity bit is derived from the data unless inverted.
  task automatic send_frame(input logic [7:0] d, input logic b8, input logic [1:0] par,
                            input logic s2, input logic inv_par, input logic stop0,
                            input exp_t e);
    logic p;
    parity   = par;
    stop_bit = s2;
    bits_num = b8;
    exp_q.push_back(e);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < (b8 ? 8 : 7); i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (par == PAR_ODD || par == PAR_EVEN) begin
      p = b8 ? ^d : ^d[6:0];
      if (par == PAR_ODD) p = ~p;
      rx = p ^ inv_par;
      wait_ticks(16);
    end
    rx = ~stop0;
    wait_ticks(16);
    if (s2) begin
      rx = 1'b1;
      wait_ticks(16);
    end
    rx = 1'b1;
  endtask

  initial begin
    #2 rst_req = 1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(32);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b1, PAR_NONE, 1'b0, 1'b0, 1'b0, '{8'hA5, 1'b0, 1'b0, 1'b0});
    wait_ticks(16);
    // 7E2 0x35, then the same frame with the parity bit inverted
    send_frame(8'h35, 1'b0, PAR_EVEN, 1'b1, 1'b0, 1'b0, '{8'h35, 1'b0, 1'b0, 1'b0});
    wait_ticks(16);
    send_frame(8'h35, 1'b0, PAR_EVEN, 1'b1, 1'b1, 1'b0, '{8'h35, 1'b1, 1'b0, 1'b0});
    wait_ticks(16);
    // 8O1 0xFF with a low stop bit, line kept low, then a clean 0x12
    send_frame(8'hFF, 1'b1, PAR_ODD, 1'b0, 1'b0, 1'b1, '{8'hFF, 1'b0, 1'b1, 1'b0});
    rx = 1'b0;
    wait_ticks(40);
    rx = 1'b1;
    wait_ticks(32);
    send_frame(8'h12, 1'b1, PAR_ODD, 1'b0, 1'b0, 1'b0, '{8'h12, 1'b0, 1'b0, 1'b0});
    wait_ticks(16);
    // 5-tick glitch: must not produce a frame
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    wait_ticks(48);
    // Line held low for 20 bit times in 8N1
    parity   = PAR_NONE;
    stop_bit = 1'b0;
    bits_num = 1'b1;
    exp_q.push_back('{8'h00, 1'b0, 1'b1, BrkExp});
    rx = 1'b0;
    wait_ticks(320);
    rx = 1'b1;
    wait_ticks(32);
    // Good frame so the outputs are non-zero, then a frame aborted by reset mid-DATA
    send_frame(8'h3C, 1'b1, PAR_NONE, 1'b0, 1'b0, 1'b0, '{8'h3C, 1'b0, 1'b0, 1'b0});
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(16);
    rx = 1'b0;
    wait_ticks(8);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(posedge clk);
    rst_req++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(32);
    send_frame(8'hC3, 1'b1, PAR_NONE, 1'b0, 1'b0, 1'b0, '{8'hC3, 1'b0, 1'b0, 1'b0});
    wait_ticks(32);
    end_req = 1'b1;
  end

endmodule
